data_mem_ctrl: RTL and testbench

Data-side memory controller between the pipeline's MEM stage and main data memory. It holds a 4-line direct-mapped write-back cache with 128-bit blocks and serves word and byte loads and stores. Misses are resolved by writing back a dirty victim, then refilling from memory, with the pipeline stalled throughout. It is the write-capable counterpart of the instruction-side controller and uses the same address split and block width.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/data_mem_ctrl_if.sv | 34 +++
 rtl/dcache_array.sv | 68 ++++++
 rtl/data_mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-side memory controller: address split, block
// width and FSM state encoding.
package mem_pkg;

  // Block geometry.
  localparam int unsigned BLOCK_BITS  = 128;
  localparam int unsigned BLOCK_BYTES = BLOCK_BITS / 8;

  // Address split for the default 4-line cache.
  localparam int unsigned TAG_MSB   = 31;
  localparam int unsigned TAG_LSB   = 6;
  localparam int unsigned INDEX_MSB = 5;
  localparam int unsigned INDEX_LSB = 4;
  localparam int unsigned WORD_MSB  = 3;
  localparam int unsigned WORD_LSB  = 2;
  localparam int unsigned BYTE_MSB  = 1;
  localparam int unsigned BYTE_LSB  = 0;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_e;

  // Byte-lane enables within a block for a word or single-byte store.
  function automatic logic [BLOCK_BYTES-1:0] lane_mask(input logic       byte_access,
                                                       input logic [1:0] word_sel,
                                                       input logic [1:0] byte_sel);
    logic [BLOCK_BYTES-1:0] mask;
    if (byte_access) begin
      mask = 16'h0001 << {word_sel, byte_sel};
    end else begin
      mask = 16'h000F << {word_sel, 2'b00};
    end
    return mask;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Pipeline-side request signals and memory-side block bus of the data cache.
interface data_mem_ctrl_if;
  import mem_pkg::*;

  // Pipeline side.
  logic                  read;
  logic                  write;
  logic                  byte_access;
  logic [31:0]           address;
  logic [31:0]           data_in;
  logic [31:0]           data_out;
  logic                  stall;

  // Memory side.
  logic                  mem_read;
  logic                  mem_write;
  logic [31:0]           mem_address;
  logic [BLOCK_BITS-1:0] mem_wdata;
  logic [BLOCK_BITS-1:0] mem_rdata;
  logic                  mem_ready;

  // Controller view.
  modport slave (
    input  read, write, byte_access, address, data_in, mem_rdata, mem_ready,
    output data_out, stall, mem_read, mem_write, mem_address, mem_wdata
  );

  // Environment view: pipeline plus main memory.
  modport master (
    output read, write, byte_access, address, data_in, mem_rdata, mem_ready,
    input  data_out, stall, mem_read, mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/dcache_array.sv
// Direct-mapped line storage: combinational read of one line, byte-lane store
// and whole-block refill, with valid/dirty bookkeeping.
module dcache_array
  import mem_pkg::*;
#(
  parameter int unsigned LINES  = 4,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned TAG_W  = 26
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [IDX_W-1:0]       index,
  // Read port for the addressed line.
  output logic                   valid,
  output logic                   dirty,
  output logic [TAG_W-1:0]       tag,
  output logic [BLOCK_BITS-1:0]  block,
  // Store port: byte lanes of the addressed line, marks it dirty.
  input  logic                   store_en,
  input  logic [BLOCK_BYTES-1:0] byte_en,
  input  logic [BLOCK_BITS-1:0]  store_data,
  // Refill port: whole line, marks it valid and clean.
  input  logic                   fill_en,
  input  logic [TAG_W-1:0]       fill_tag,
  input  logic [BLOCK_BITS-1:0]  fill_block
);

  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;
  logic [TAG_W-1:0]      tag_q   [LINES];
  logic [BLOCK_BITS-1:0] block_q [LINES];

  // Combinational read of the addressed line.
  always_comb begin
    valid = valid_q[index];
    dirty = dirty_q[index];
    tag   = tag_q[index];
    block = block_q[index];
  end

  // Line state bits; the only storage cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (store_en) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the line is valid.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_q[index]   <= fill_tag;
      block_q[index] <= fill_block;
    end else if (store_en) begin
      for (int unsigned b = 0; b < BLOCK_BYTES; b++) begin
        if (byte_en[b]) begin
          block_q[index][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: direct-mapped write-back cache with word/byte
// access. Misses write back a dirty victim, then refill, stalling the pipeline.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned LINES = 4
) (
  input logic            clock,
  input logic            reset,
  data_mem_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = TAG_MSB + 1 - INDEX_LSB - IDX_W;

  logic [IDX_W-1:0]       index;
  logic [TAG_W-1:0]       req_tag;
  logic [1:0]             word_sel;
  logic [1:0]             byte_sel;
  logic                   request;
  logic                   hit;

  logic                   line_valid;
  logic                   line_dirty;
  logic [TAG_W-1:0]       line_tag;
  logic [BLOCK_BITS-1:0]  line_block;

  logic                   store_en;
  logic                   fill_en;
  logic [BLOCK_BYTES-1:0] byte_en;
  logic [BLOCK_BITS-1:0]  store_data;
  logic [31:0]            word_data;

  state_e                 state_q;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [31:0]            mem_address_q;
  logic [BLOCK_BITS-1:0]  mem_wdata_q;

  assign index    = bus.address[INDEX_LSB +: IDX_W];
  assign req_tag  = bus.address[TAG_MSB -: TAG_W];
  assign word_sel = bus.address[WORD_MSB:WORD_LSB];
  assign byte_sel = bus.address[BYTE_MSB:BYTE_LSB];
  assign request  = bus.read | bus.write;
  assign hit      = line_valid && (line_tag == req_tag);

  // A write (also when read is high) hitting in IDLE commits at the next edge.
  assign store_en = (state_q == IDLE) && bus.write && hit;
  assign fill_en  = (state_q == REFILL) && bus.mem_ready;

  // Store lanes and data replicated across the block.
  always_comb begin
    byte_en    = lane_mask(bus.byte_access, word_sel, byte_sel);
    store_data = bus.byte_access ? {BLOCK_BYTES{bus.data_in[7:0]}} : {4{bus.data_in}};
  end

  // Load result from the addressed word or zero-extended byte.
  always_comb begin
    word_data    = line_block[{word_sel, 5'b00000} +: 32];
    bus.data_out = bus.byte_access ? {24'h0, word_data[{byte_sel, 3'b000} +: 8]} : word_data;
  end

  // Stall on a miss in IDLE and throughout a transfer; reset drops it at once.
  always_comb begin
    if (reset) begin
      bus.stall = 1'b0;
    end else if (state_q != IDLE) begin
      bus.stall = 1'b1;
    end else begin
      bus.stall = request && !hit;
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clock      (clock),
    .reset      (reset),
    .index      (index),
    .valid      (line_valid),
    .dirty      (line_dirty),
    .tag        (line_tag),
    .block      (line_block),
    .store_en   (store_en),
    .byte_en    (byte_en),
    .store_data (store_data),
    .fill_en    (fill_en),
    .fill_tag   (req_tag),
    .fill_block (bus.mem_rdata)
  );

  // Miss FSM with registered memory-bus outputs held for the whole transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (request && !hit) begin
            if (line_valid && line_dirty) begin
              state_q       <= WRITEBACK;
              mem_write_q   <= 1'b1;
              mem_address_q <= {line_tag, index, 4'b0000};
              mem_wdata_q   <= line_block;
            end else begin
              state_q       <= REFILL;
              mem_read_q    <= 1'b1;
              mem_address_q <= {bus.address[31:4], 4'b0000};
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ready) begin
            state_q       <= REFILL;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b1;
            mem_address_q <= {bus.address[31:4], 4'b0000};
          end
        end
        REFILL: begin
          // The line is filled by the array on this edge; the request then hits.
          if (bus.mem_ready) begin
            state_q    <= IDLE;
            mem_read_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: golden flat memory for load results,
// separate backing memory for refills and write-backs, transfer log for the
// memory-bus sequence.
module tb_data_mem_ctrl;

  logic clock;
  logic reset;

  int n_checks;
  int n_errors;

  typedef struct packed {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } xfer_t;

  logic [31:0]  exp_q[$];
  xfer_t        xfer_q[$];
  logic [31:0]  gold [logic [31:0]];
  logic [127:0] back [logic [31:0]];

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(
    .LINES (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Initial contents of main memory; block 0x40 holds {4,3,2,1}.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a[31:4] == 28'h4) return 32'd1 + {30'h0, a[3:2]};
    return a ^ 32'h5A5A_0000 ^ {a[23:0], 8'h3C};
  endfunction

  function automatic logic [31:0] get_word(input logic [31:0] wa);
    if (gold.exists(wa)) return gold[wa];
    return init_word(wa);
  endfunction

  function automatic logic [127:0] get_block(input logic [31:0] ba);
    if (back.exists(ba)) return back[ba];
    return {init_word(ba + 12), init_word(ba + 8), init_word(ba + 4), init_word(ba)};
  endfunction

  // One pipeline access, servicing memory with the given ready delay.
  task automatic do_access(input logic wr, input logic bt, input logic [31:0] addr,
                           input logic [31:0] wdata, input int delay, output int stalls);
    logic [31:0]  wa;
    logic [31:0]  w;
    logic [31:0]  snap_addr;
    logic [127:0] snap_wdata;
    logic         snap_wr;
    logic         in_xfer;
    logic         ready;
    logic         done;
    int           cycles;
    int           wait_cnt;
    xfer_t        x;
    wa = {addr[31:2], 2'b00};
    if (!wr) begin
      w = get_word(wa);
      exp_q.push_back(bt ? {24'h0, w[{addr[1:0], 3'b000} +: 8]} : w);
    end
    bus.read        = !wr;
    bus.write       = wr;
    bus.byte_access = bt;
    bus.address     = addr;
    bus.data_in     = wdata;
    stalls   = 0;
    cycles   = 0;
    wait_cnt = 0;
    in_xfer  = 1'b0;
    done     = 1'b0;
    snap_addr  = '0;
    snap_wdata = '0;
    snap_wr    = 1'b0;
    while (!done) begin
      @(negedge clock);
      ready = 1'b0;
      check_eq("mem_excl", bus.mem_read & bus.mem_write, 1'b0);
      if (!bus.stall) begin
        if (!wr) check_eq("load", bus.data_out, exp_q.pop_front());
        done = 1'b1;
      end else begin
        stalls++;
        if (bus.mem_read || bus.mem_write) begin
          if (!in_xfer) begin
            in_xfer    = 1'b1;
            wait_cnt   = 0;
            snap_wr    = bus.mem_write;
            snap_addr  = bus.mem_address;
            snap_wdata = bus.mem_wdata;
            x.wr    = bus.mem_write;
            x.addr  = bus.mem_address;
            x.wdata = bus.mem_wdata;
            xfer_q.push_back(x);
          end else begin
            check_eq("hold_kind", bus.mem_write, snap_wr);
            check_eq("hold_addr", bus.mem_address, snap_addr);
            if (snap_wr) check_eq("hold_wdata", bus.mem_wdata, snap_wdata);
          end
          if (wait_cnt == delay) begin
            ready = 1'b1;
            bus.mem_ready = 1'b1;
            if (bus.mem_write) back[bus.mem_address] = bus.mem_wdata;
            else bus.mem_rdata = get_block(bus.mem_address);
          end
        end
        cycles++;
        if (cycles > 200) begin
          check_eq("timeout", bus.stall, 1'b0);
          exp_q.delete();
          done = 1'b1;
        end
      end
      @(posedge clock);
      #1;
      bus.mem_ready = 1'b0;
      if (ready) in_xfer = 1'b0;
      else if (in_xfer) wait_cnt++;
    end
    if (wr) begin
      w = get_word(wa);
      if (bt) w[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
      else w = wdata;
      gold[wa] = w;
    end
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog got running expected finished");
    $fatal(1);
  end

  initial begin : main
    int  st;
    logic seen;
    logic        r_wr;
    logic        r_bt;
    logic [31:0] r_addr;
    n_checks = 0;
    n_errors = 0;
    reset           = 1'b1;
    bus.read        = 1'b0;
    bus.write       = 1'b0;
    bus.byte_access = 1'b0;
    bus.address     = '0;
    bus.data_in     = '0;
    bus.mem_rdata   = '0;
    bus.mem_ready   = 1'b0;

    // Reset state.
    @(posedge clock);
    @(negedge clock);
    check_eq("rst_stall", bus.stall, 1'b0);
    check_eq("rst_mem_read", bus.mem_read, 1'b0);
    check_eq("rst_mem_write", bus.mem_write, 1'b0);
    check_eq("rst_mem_address", bus.mem_address, 32'h0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 128'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Clean miss on 0x40, immediate ready.
    xfer_q.delete();
    do_access(1'b0, 1'b0, 32'h40, 32'h0, 0, st);
    check_eq("clean_stalls", st, 2);
    check_eq("clean_nxfer", xfer_q.size(), 1);
    if (xfer_q.size() > 0) begin
      check_eq("clean_kind", xfer_q[0].wr, 1'b0);
      check_eq("clean_addr", xfer_q[0].addr, 32'h40);
    end

    // Word store hit, then byte store and loads.
    do_access(1'b1, 1'b0, 32'h44, 32'hDEADBEEF, 0, st);
    check_eq("store_hit_stalls", st, 0);
    do_access(1'b0, 1'b0, 32'h44, 32'h0, 0, st);
    check_eq("load_hit_stalls", st, 0);
    do_access(1'b1, 1'b1, 32'h46, 32'h123456AA, 0, st);
    check_eq("byte_store_stalls", st, 0);
    do_access(1'b0, 1'b0, 32'h44, 32'h0, 0, st);
    do_access(1'b0, 1'b1, 32'h46, 32'h0, 0, st);
    do_access(1'b0, 1'b1, 32'h47, 32'h0, 0, st);

    // Dirty miss on 0x80: write-back of 0x40, then refill.
    xfer_q.delete();
    do_access(1'b0, 1'b0, 32'h80, 32'h0, 2, st);
    check_eq("dirty_stalls", st, 7);
    check_eq("dirty_nxfer", xfer_q.size(), 2);
    if (xfer_q.size() > 1) begin
      check_eq("wb_kind", xfer_q[0].wr, 1'b1);
      check_eq("wb_addr", xfer_q[0].addr, 32'h40);
      check_eq("wb_word1", xfer_q[0].wdata[63:32], 32'hDEAABEEF);
      check_eq("rf_kind", xfer_q[1].wr, 1'b0);
      check_eq("rf_addr", xfer_q[1].addr, 32'h80);
    end

    // Reset in the middle of a refill of 0xC0.
    bus.read        = 1'b1;
    bus.write       = 1'b0;
    bus.byte_access = 1'b0;
    bus.address     = 32'hC0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (bus.mem_read) begin
        seen = 1'b1;
      end else begin
        @(posedge clock);
        #1;
      end
    end
    check_eq("rst_refill_reached", bus.mem_read, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_mem_read", bus.mem_read, 1'b0);
    check_eq("rst_mid_stall", bus.stall, 1'b0);
    check_eq("rst_mid_mem_address", bus.mem_address, 32'h0);
    @(posedge clock);
    #1;
    bus.read = 1'b0;
    reset    = 1'b0;

    // 0x80 was invalidated by reset: clean miss again.
    xfer_q.delete();
    do_access(1'b0, 1'b0, 32'h80, 32'h0, 0, st);
    check_eq("post_rst_stalls", st, 2);
    check_eq("post_rst_nxfer", xfer_q.size(), 1);
    if (xfer_q.size() > 0) check_eq("post_rst_addr", xfer_q[0].addr, 32'h80);

    // Stretched ready: 1 cycle on a clean store miss, 7 on a dirty load miss.
    do_access(1'b1, 1'b0, 32'h104, 32'hCAFEF00D, 1, st);
    check_eq("stretch1_stalls", st, 3);
    xfer_q.delete();
    do_access(1'b0, 1'b0, 32'h140, 32'h0, 7, st);
    check_eq("stretch7_stalls", st, 17);
    check_eq("stretch7_nxfer", xfer_q.size(), 2);
    if (xfer_q.size() > 1) begin
      check_eq("stretch7_wb_addr", xfer_q[0].addr, 32'h100);
      check_eq("stretch7_wb_word1", xfer_q[0].wdata[63:32], 32'hCAFEF00D);
      check_eq("stretch7_rf_addr", xfer_q[1].addr, 32'h140);
    end
    do_access(1'b0, 1'b0, 32'h104, 32'h0, 3, st);

    // Random mix over four tags per index.
    for (int n = 0; n < 60; n++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_bt   = 1'($urandom_range(0, 1));
      r_addr = {24'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'b00};
      if (r_bt) r_addr[1:0] = 2'($urandom_range(0, 3));
      do_access(r_wr, r_bt, r_addr, $urandom, int'($urandom_range(0, 3)), st);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
